// File: rtl/candidate_dispatcher_if.sv
// Handshake bundle between the candidate dispatcher and its controller/consumer.
interface candidate_dispatcher_if #(parameter int bs = 16);
   localparam int bs_bits = $clog2(bs);

   logic               start;
   logic [0:bs-1]      candidate_list;
   logic               abort;
   logic               busy;
   logic               out_valid;
   logic               out_ready;
   logic [bs_bits-1:0] out_idx;
   logic [bs_bits-1:0] out_slot;
   logic               out_last;
   logic               done;
   logic [bs_bits:0]   total_count;

   modport master (
      output start, candidate_list, abort, out_ready,
      input  busy, out_valid, out_idx, out_slot, out_last, done, total_count
   );

   modport slave (
      input  start, candidate_list, abort, out_ready,
      output busy, out_valid, out_idx, out_slot, out_last, done, total_count
   );
endinterface

// File: rtl/candidate_dispatcher.sv
// Issues the index of each set candidate bit, lowest first, tagged with its
// compacted slot number; pulses done with the total count at the end of a pass.
module candidate_dispatcher #(
   parameter int bs = 16
) (
   input logic                   clk,
   input logic                   rst,
   candidate_dispatcher_if.slave bus
);
   localparam int bs_bits = $clog2(bs);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]         state;
   logic [0:bs-1]      pending;
   logic [bs_bits-1:0] slot;
   logic [bs_bits:0]   total_count;

   logic [bs_bits-1:0] lo_idx;
   logic               single;
   logic [bs_bits:0]   slot_inc;
   logic               xfer;

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      lo_idx = '0;
      for (int i = bs - 1; i >= 0; i--)
         if (pending[i]) lo_idx = i[bs_bits-1:0];
   end

   assign single   = (pending != '0) && ((pending & (pending - 1'b1)) == '0);
   assign slot_inc = {1'b0, slot} + {{bs_bits{1'b0}}, 1'b1};

   assign bus.busy        = (state != IDLE);
   assign bus.out_valid   = (state == ISSUE) && !bus.abort;
   assign bus.out_idx     = (state == ISSUE) ? lo_idx : '0;
   assign bus.out_slot    = (state == ISSUE) ? slot : '0;
   assign bus.out_last    = (state == ISSUE) && single;
   assign bus.done        = (state == DONE) && !bus.abort;
   assign bus.total_count = total_count;

   assign xfer = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pending     <= '0;
         slot        <= '0;
         total_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  pending <= bus.candidate_list;
                  slot    <= '0;
                  if (bus.candidate_list != '0) begin
                     state <= ISSUE;
                  end else begin
                     state       <= DONE;
                     total_count <= '0;
                  end
               end
            end
            ISSUE: begin
               if (bus.abort) begin
                  state   <= IDLE;
                  pending <= '0;
               end else if (xfer) begin
                  pending[lo_idx] <= 1'b0;
                  slot            <= slot_inc[bs_bits-1:0];
                  if (single) begin
                     state       <= DONE;
                     total_count <= slot_inc;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (bus.abort) pending <= '0;
            end
            default: begin
               state   <= IDLE;
               pending <= '0;
            end
         endcase
      end
   end
endmodule
